// File: rtl/lane_read_train_pkg.sv
// Shared types and default constants for the per-lane read-eye training controller.
// The state encodings below are the values exported on TRAIN_STATE.
package lane_read_train_pkg;

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StLoad     = 4'd1,
    StWait     = 4'd2,
    StClear    = 4'd3,
    StSample   = 4'd4,
    StEval     = 4'd5,
    StStep     = 4'd6,
    StSeek     = 4'd7,
    StSeekWait = 4'd8,
    StDone     = 4'd9
  } train_state_e;

  localparam int unsigned DefMaxTap    = 128;
  localparam int unsigned DefSettleCyc = 8;
  localparam int unsigned DefSampleCyc = 64;

endpackage

// File: rtl/lane_eye_run_tracker.sv
// Tracks the current and best contiguous passing-tap run during the delay sweep
// and reports the centre tap of the best run.
module lane_eye_run_tracker
  import lane_read_train_pkg::*;
#(
  parameter int unsigned TAP_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             eval_i,
  input  logic             pass_i,
  input  logic             last_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic [TAP_W-1:0] best_start_o,
  output logic [TAP_W-1:0] best_len_o,
  output logic [TAP_W-1:0] best_len_nxt_o,
  output logic [TAP_W-1:0] centre_o
);

  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [TAP_W-1:0] cur_len_q, cur_len_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [TAP_W-1:0] best_len_q, best_len_d;
  logic [TAP_W-1:0] cand_start, cand_len, half_len;

  always_comb begin
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    cand_start   = cur_start_q;
    cand_len     = cur_len_q;
    if (pass_i) begin
      cand_start = (cur_len_q == '0) ? tap_i : cur_start_q;
      cand_len   = cur_len_q + TAP_W'(1);
    end
    if (clear_i) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (eval_i) begin
      cur_start_d = cand_start;
      cur_len_d   = pass_i ? cand_len : '0;
      // A run is only scored once it closes; strict compare keeps the lowest start on ties.
      if ((!pass_i || last_i) && (cand_len > best_len_q)) begin
        best_start_d = cand_start;
        best_len_d   = cand_len;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  always_comb begin
    half_len = (best_len_q == '0) ? '0 : ((best_len_q - TAP_W'(1)) >> 1);
    centre_o = best_start_q + half_len;
  end

  assign best_start_o   = best_start_q;
  assign best_len_o     = best_len_q;
  assign best_len_nxt_o = best_len_d;

endmodule

// File: rtl/lane_read_eye_trainer.sv
// Per-lane read-eye trainer: sweeps the IOD delay line, scores taps, parks at eye centre.
// Optional status outputs (TRAIN_STATE, EYE_START) exist only with READ_TRAIN_STATUS_EN.
module lane_read_eye_trainer
  import lane_read_train_pkg::*;
#(
  parameter int unsigned MAX_TAP    = DefMaxTap,
  parameter int unsigned TAP_W      = 8,
  parameter int unsigned SETTLE_CYC = DefSettleCyc,
  parameter int unsigned SAMPLE_CYC = DefSampleCyc
) (
  input  logic             FAB_CLK,
  input  logic             SYNC_RST,
  input  logic             TRAIN_START,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_FAIL,
  output logic [TAP_W-1:0] FINAL_TAP,
  output logic [TAP_W-1:0] EYE_WIDTH
`ifdef READ_TRAIN_STATUS_EN
  ,
  output logic [3:0]       TRAIN_STATE,
  output logic [TAP_W-1:0] EYE_START
`endif
);

  localparam int unsigned CntMax = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0]  SettleLd = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0]  SampleLd = CntW'(SAMPLE_CYC - 1);
  localparam logic [TAP_W-1:0] LastTap  = TAP_W'(MAX_TAP - 1);

  train_state_e     state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             tap_fail_q, tap_fail_d;
  logic             oor_q, oor_d;
  logic             fail_pend_q, fail_pend_d;
  logic             dir_q, dir_d;
  logic             train_fail_q, train_fail_d;
  logic [TAP_W-1:0] final_tap_q, final_tap_d;
  logic [TAP_W-1:0] eye_width_q, eye_width_d;
`ifdef READ_TRAIN_STATUS_EN
  logic [TAP_W-1:0] eye_start_q, eye_start_d;
`endif

  logic             load, move, clr_flags, trk_clear, trk_eval, scan_last;
  logic [TAP_W-1:0] best_start, best_len, best_len_nxt, centre;

  lane_eye_run_tracker #(
    .TAP_W(TAP_W)
  ) u_run_tracker (
    .clk_i         (FAB_CLK),
    .rst_i         (SYNC_RST),
    .clear_i       (trk_clear),
    .eval_i        (trk_eval),
    .pass_i        (!tap_fail_q),
    .last_i        (scan_last),
    .tap_i         (tap_q),
    .best_start_o  (best_start),
    .best_len_o    (best_len),
    .best_len_nxt_o(best_len_nxt),
    .centre_o      (centre)
  );

  assign scan_last = (tap_q == LastTap) || oor_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tap_d        = tap_q;
    tap_fail_d   = tap_fail_q;
    oor_d        = oor_q;
    fail_pend_d  = fail_pend_q;
    dir_d        = dir_q;
    train_fail_d = train_fail_q;
    final_tap_d  = final_tap_q;
    eye_width_d  = eye_width_q;
`ifdef READ_TRAIN_STATUS_EN
    eye_start_d  = eye_start_q;
`endif
    load      = 1'b0;
    move      = 1'b0;
    clr_flags = 1'b0;
    trk_clear = 1'b0;
    trk_eval  = 1'b0;

    // Out-of-range anywhere in the settle/score window kills this tap and ends the scan.
    if ((state_q == StWait || state_q == StClear || state_q == StSample) &&
        DELAY_LINE_OUT_OF_RANGE) begin
      tap_fail_d = 1'b1;
      oor_d      = 1'b1;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (TRAIN_START) begin
          state_d      = StLoad;
          tap_d        = '0;
          trk_clear    = 1'b1;
          train_fail_d = 1'b0;
          fail_pend_d  = 1'b0;
          oor_d        = 1'b0;
        end
      end
      StLoad: begin
        load = 1'b1;
        if (fail_pend_q) begin
          state_d      = StDone;
          tap_d        = '0;
          train_fail_d = 1'b1;
          final_tap_d  = '0;
          eye_width_d  = '0;
`ifdef READ_TRAIN_STATUS_EN
          eye_start_d  = '0;
`endif
        end else begin
          state_d    = StWait;
          cnt_d      = SettleLd;
          tap_fail_d = 1'b0;
        end
      end
      StWait: begin
        if (cnt_q == '0) state_d = StClear;
        else cnt_d = cnt_q - CntW'(1);
      end
      StClear: begin
        clr_flags = 1'b1;
        state_d   = StSample;
        cnt_d     = SampleLd;
      end
      StSample: begin
        if (EYE_MONITOR_EARLY || EYE_MONITOR_LATE) tap_fail_d = 1'b1;
        if (cnt_q == '0) state_d = StEval;
        else cnt_d = cnt_q - CntW'(1);
      end
      StEval: begin
        trk_eval = 1'b1;
        if (scan_last) begin
          if (best_len_nxt == '0) begin
            fail_pend_d = 1'b1;
            state_d     = StLoad;
          end else begin
            state_d = StSeek;
          end
        end else begin
          state_d = StStep;
        end
      end
      StStep: begin
        move       = 1'b1;
        dir_d      = 1'b1;
        tap_d      = tap_q + TAP_W'(1);
        state_d    = StWait;
        cnt_d      = SettleLd;
        tap_fail_d = 1'b0;
      end
      StSeek: begin
        if (tap_q == centre) begin
          state_d     = StDone;
          final_tap_d = tap_q;
          eye_width_d = best_len;
`ifdef READ_TRAIN_STATUS_EN
          eye_start_d = best_start;
`endif
        end else begin
          move    = 1'b1;
          dir_d   = 1'b0;
          tap_d   = tap_q - TAP_W'(1);
          state_d = StSeekWait;
          cnt_d   = SettleLd;
        end
      end
      StSeekWait: begin
        if (cnt_q == '0) state_d = StSeek;
        else cnt_d = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tap_q        <= '0;
      tap_fail_q   <= 1'b0;
      oor_q        <= 1'b0;
      fail_pend_q  <= 1'b0;
      dir_q        <= 1'b0;
      train_fail_q <= 1'b0;
      final_tap_q  <= '0;
      eye_width_q  <= '0;
`ifdef READ_TRAIN_STATUS_EN
      eye_start_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      tap_fail_q   <= tap_fail_d;
      oor_q        <= oor_d;
      fail_pend_q  <= fail_pend_d;
      dir_q        <= dir_d;
      train_fail_q <= train_fail_d;
      final_tap_q  <= final_tap_d;
      eye_width_q  <= eye_width_d;
`ifdef READ_TRAIN_STATUS_EN
      eye_start_q  <= eye_start_d;
`endif
    end
  end

  // Direction must be valid in the MOVE cycle itself, so expose the next value.
  assign DELAY_LINE_DIRECTION    = dir_d;
  assign DELAY_LINE_LOAD         = load;
  assign DELAY_LINE_MOVE         = move;
  assign EYE_MONITOR_CLEAR_FLAGS = clr_flags;
  assign TRAIN_BUSY              = (state_q != StIdle) && (state_q != StDone);
  assign TRAIN_DONE              = (state_q == StDone);
  assign TRAIN_FAIL              = train_fail_q;
  assign FINAL_TAP               = final_tap_q;
  assign EYE_WIDTH               = eye_width_q;
`ifdef READ_TRAIN_STATUS_EN
  assign TRAIN_STATE             = state_q;
  assign EYE_START               = eye_start_q;
`endif

endmodule

// File: tb/tb_lane_read_eye_trainer.sv
// Directed table-driven bench for lane_read_eye_trainer with a small IOD delay-line model.
module tb_lane_read_eye_trainer;

  localparam int unsigned TapW = 8;

  logic            fab_clk = 1'b0;
  logic            sync_rst = 1'b1;
  logic            train_start = 1'b0;
  logic            early = 1'b0;
  logic            late = 1'b0;
  logic            oor = 1'b0;
  logic            dl_load, dl_move, dl_dir, clr_flags, busy, done, fail;
  logic [TapW-1:0] final_tap, eye_width;
`ifdef READ_TRAIN_STATUS_EN
  logic [3:0]      train_state;
  logic [TapW-1:0] eye_start;
`endif

  lane_read_eye_trainer #(
    .MAX_TAP   (16),
    .TAP_W     (TapW),
    .SETTLE_CYC(2),
    .SAMPLE_CYC(4)
  ) dut (
    .FAB_CLK                (fab_clk),
    .SYNC_RST               (sync_rst),
    .TRAIN_START            (train_start),
    .EYE_MONITOR_EARLY      (early),
    .EYE_MONITOR_LATE       (late),
    .DELAY_LINE_OUT_OF_RANGE(oor),
    .DELAY_LINE_LOAD        (dl_load),
    .DELAY_LINE_MOVE        (dl_move),
    .DELAY_LINE_DIRECTION   (dl_dir),
    .EYE_MONITOR_CLEAR_FLAGS(clr_flags),
    .TRAIN_BUSY             (busy),
    .TRAIN_DONE             (done),
    .TRAIN_FAIL             (fail),
    .FINAL_TAP              (final_tap),
    .EYE_WIDTH              (eye_width)
`ifdef READ_TRAIN_STATUS_EN
    ,
    .TRAIN_STATE            (train_state),
    .EYE_START              (eye_start)
`endif
  );

  always #5 fab_clk = ~fab_clk;

  // IOD model state: pass mask per tap, out-of-range threshold, one-shot glitch tap.
  logic [15:0] mask = 16'h0000;
  int          oor_tap = 99;
  int          gtap = -1;
  int          mtap = 0;
  int          gcnt = 0;
  int          n_load = 0, n_inc = 0, n_dec = 0, n_viol = 0, n_clr = 0;
  int          n_chk = 0, n_err = 0;

  always @(negedge fab_clk) begin
    if ((int'(dl_load) + int'(dl_move) + int'(clr_flags)) > 1) n_viol++;
    if (dl_load) begin
      mtap = 0;
      n_load++;
    end else if (dl_move) begin
      if (dl_dir) begin
        mtap++;
        n_inc++;
      end else begin
        mtap--;
        n_dec++;
      end
    end
    if (clr_flags) n_clr++;
    if (clr_flags && mtap == gtap) gcnt = 2;
    else if (gcnt > 0) gcnt--;
    early = (!mask[mtap[3:0]] && mtap < 8) || (gcnt == 1);
    late  = !mask[mtap[3:0]] && mtap >= 8;
    oor   = (mtap >= oor_tap);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " load"}, int'(dl_load), 0);
    chk({tag, " move"}, int'(dl_move), 0);
    chk({tag, " dir"}, int'(dl_dir), 0);
    chk({tag, " clr"}, int'(clr_flags), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " fail"}, int'(fail), 0);
    chk({tag, " final_tap"}, int'(final_tap), 0);
    chk({tag, " eye_width"}, int'(eye_width), 0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          oor_tap;
    int          gtap;
    int          exp_tap;
    int          exp_width;
    int          exp_fail;
    int          exp_inc;
    int          exp_dec;
    int          exp_loads;
    int          exp_cyc;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int n;
    int l0, i0, d0;
    mask    = v.mask;
    oor_tap = v.oor_tap;
    gtap    = v.gtap;
    l0 = n_load;
    i0 = n_inc;
    d0 = n_dec;
    @(posedge fab_clk); #1 train_start = 1'b1;
    @(posedge fab_clk); #1 train_start = 1'b0;
    chk({v.name, " load_latency"}, int'(dl_load), 1);
    chk({v.name, " busy_with_load"}, int'(busy), 1);
    n = 0;
    while (!done && n < 1000) begin
      @(posedge fab_clk); #1;
      n++;
      train_start = (n == 20);  // spurious start mid-scan must be ignored
    end
    train_start = 1'b0;
    chk({v.name, " cycles_to_done"}, n, v.exp_cyc);
    chk({v.name, " final_tap"}, int'(final_tap), v.exp_tap);
    chk({v.name, " eye_width"}, int'(eye_width), v.exp_width);
    chk({v.name, " train_fail"}, int'(fail), v.exp_fail);
    chk({v.name, " inc_moves"}, n_inc - i0, v.exp_inc);
    chk({v.name, " dec_moves"}, n_dec - d0, v.exp_dec);
    chk({v.name, " load_pulses"}, n_load - l0, v.exp_loads);
    chk({v.name, " busy_low_in_done"}, int'(busy), 0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    int c0;
    vecs[0] = '{"single_eye", 16'h07E0, 99, -1, 7, 6, 0, 15, 8, 1, 169};
    vecs[1] = '{"two_equal", 16'h0E1C, 99, -1, 3, 3, 0, 15, 12, 1, 181};
    vecs[2] = '{"no_pass", 16'h0000, 99, -1, 0, 0, 1, 15, 0, 2, 145};
    vecs[3] = '{"oor_tap12", 16'hFF00, 12, -1, 9, 4, 0, 12, 3, 1, 127};
    vecs[4] = '{"glitch_tap6", 16'h03F0, 99, 6, 8, 3, 0, 15, 7, 1, 166};
    vecs[5] = '{"all_pass", 16'hFFFF, 99, -1, 7, 16, 0, 15, 8, 1, 169};
    vecs[6] = '{"open_top", 16'hE000, 99, -1, 14, 3, 0, 15, 1, 1, 148};

    repeat (3) @(posedge fab_clk);
    #1 chk_idle_outputs("reset");
    sync_rst = 1'b0;
    @(posedge fab_clk); #1;
    chk_idle_outputs("idle");

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    chk("dir_held_after_seek", int'(dl_dir), 0);
    chk("done_level_held", int'(done), 1);

    // Abort with reset while sampling the second tap (direction register is 1 here).
    mask = 16'hFFFF;
    oor_tap = 99;
    gtap = -1;
    c0 = n_clr;
    @(posedge fab_clk); #1 train_start = 1'b1;
    @(posedge fab_clk); #1 train_start = 1'b0;
    n = 0;
    while ((n_clr - c0) < 2 && n < 200) begin
      @(posedge fab_clk); #1;
      n++;
    end
    chk("reach_second_clear", int'(n < 200), 1);
    chk("busy_mid_scan", int'(busy), 1);
    @(posedge fab_clk); #1 sync_rst = 1'b1;
    @(posedge fab_clk); #1;
    chk_idle_outputs("mid_reset");
    sync_rst = 1'b0;
    repeat (3) @(posedge fab_clk);
    #1 chk("stay_idle_after_reset", int'(busy), 0);

    chk("one_hot_pulses", n_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
